enc_bin2onehot_stream: RTL and testbench
========================================

// Module: enc_bin2onehot_stream
// PURPOSE
//  Parametrised binary-to-one-hot/thermometer encoder with valid/ready flow control.
//  Inputs pass through a 2-entry skid pipeline, so the encoder can sit between
//  back-pressured stream stages (arbiter grant paths, decoder select paths) with no
//  combinational ready path. Indices outside the output range are flagged and
//  counted.
// PARAMETERS
//  IN_W   4   binary index width
//  OUT_W  15  encoded output width; legal range 1..2**IN_W
//  CNT_W  8   width of the saturating error counter
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   1       input beat valid
//  in_ready   out  1       encoder can accept a beat
//  in         in   IN_W    binary index
//  in_mode    in   1       0 = one-hot, 1 = thermometer; sampled with the beat
//  out_valid  out  1       encoded beat valid
//  out_ready  in   1       downstream accepts the beat
//  out        out  OUT_W   encoded word; forced to 0 when out_valid=0
//  out_err    out  1       the beat in the output register had in >= OUT_W
//  err_clr    in   1       synchronous clear of err_cnt
//  err_cnt    out  CNT_W   saturating count of accepted out-of-range beats
// BEHAVIOUR
//  Reset (rst_n low, async): state EMPTY; out_valid=0, out=0, out_err=0,
//    err_cnt=0, in_ready=1.
//  Handshakes: a transfer happens on a clk edge where valid&&ready. in_ready is
//    decoded from registered state only; it never depends combinationally on
//    out_ready.
//  Encoding, computed at acceptance and stored encoded:
//    one-hot:     out[i] = (in == i)
//    thermometer: out[i] = (i <= in)
//    If in >= OUT_W: err=1. One-hot gives all zeros; thermometer gives all ones.
//  Latency: 1 cycle. A beat accepted at edge N shows out_valid=1 after edge N.
//  State machine (main register M, skid register S):
//    EMPTY: accept -> ONE.
//    ONE (M valid):
//      in_fire && out_fire  -> ONE, M reloaded.
//      in_fire only         -> FULL, beat goes to S.
//      out_fire only        -> EMPTY.
//    FULL (M and S valid; in_ready=0):
//      out_fire -> ONE, S moves to M.
//  Stability: while out_valid && !out_ready, out, out_err and out_valid hold.
//  Ordering: beats leave in acceptance order; none are dropped or duplicated.
//  err_cnt:
//    Increments by 1 on each accepted beat with err=1.
//    Saturates at 2**CNT_W-1.
//    err_clr wins over a same-cycle increment, except that err_clr together with
//    an erroring acceptance loads 1.
//  Unused inputs: in and in_mode are ignored when in_valid=0.
//  Mid-operation reset: all buffered beats are discarded immediately; outputs
//    return to their reset values asynchronously.
// TESTING (IN_W=4, OUT_W=15, CNT_W=4)
//  1. Reset, then in_valid=0 for 3 cycles -> out_valid=0, out=0, in_ready=1,
//     err_cnt=0.
//  2. One-hot stream, out_ready=1: in=0,1,7,14 on back-to-back cycles ->
//     out = 0x0001, 0x0002, 0x0080, 0x4000, each 1 cycle after acceptance,
//     no bubbles.
//  3. Thermometer, in=5 -> out = 0x003F. Then in=15 -> out=0x7FFF, out_err=1,
//     err_cnt=1.
//  4. Back-pressure: out_ready=0 and push in=3, then in=9 -> in_ready=0 after
//     the 2nd beat; the 3rd beat is stalled and out holds 0x0008. Raise
//     out_ready -> 0x0008 then 0x0200, then the 3rd beat, in order.
//  5. Errors: 17 one-hot beats with in=15 -> err_cnt saturates at 15. err_clr
//     together with a 15 beat -> err_cnt=1.
//  6. Assert rst_n low while in FULL -> out_valid=0, out=0 at once. After
//     release, no stale beat appears.

Source files
------------

// File: rtl/enc_bin2onehot_stream.sv
// Binary index to one-hot / thermometer encoder behind a 2-entry skid buffer.
// Out-of-range indices are flagged per beat and tallied in a saturating counter.
module enc_bin2onehot_stream #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 15,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q;
    logic [OUT_W-1:0] m_data_q;
    logic [OUT_W-1:0] s_data_q;
    logic             m_err_q;
    logic             s_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [OUT_W-1:0] enc_d;
    logic             enc_err_d;
    logic             in_fire;
    logic             out_fire;

    // Out-of-range indices fall out naturally: no one-hot bit, all thermo bits.
    always_comb begin
        enc_d = '0;
        for (int i = 0; i < OUT_W; i++) begin
            enc_d[i] = in_mode ? (int'(in) >= i) : (int'(in) == i);
        end
        enc_err_d = int'(in) >= OUT_W;
    end

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out       = out_valid ? m_data_q : '0;
    assign out_err   = out_valid & m_err_q;
    assign err_cnt   = cnt_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            m_data_q <= '0;
            s_data_q <= '0;
            m_err_q  <= 1'b0;
            s_err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        m_data_q <= enc_d;
                        m_err_q  <= enc_err_d;
                        state_q  <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        m_data_q <= enc_d;
                        m_err_q  <= enc_err_d;
                    end else if (in_fire) begin
                        s_data_q <= enc_d;
                        s_err_q  <= enc_err_d;
                        state_q  <= FULL;
                    end else if (out_fire) begin
                        state_q  <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        m_data_q <= s_data_q;
                        m_err_q  <= s_err_q;
                        state_q  <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    // A clear coinciding with an erroring acceptance keeps that one error.
    always_comb begin
        cnt_d = cnt_q;
        if (err_clr) begin
            cnt_d = (in_fire && enc_err_d) ? CNT_W'(1) : '0;
        end else if (in_fire && enc_err_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_enc_bin2onehot_stream.sv
// Scoreboard bench for enc_bin2onehot_stream (IN_W=4, OUT_W=15, CNT_W=4).
// A negedge monitor pushes expected words on acceptance and pops on output.
module tb_enc_bin2onehot_stream;

    localparam int IN_W  = 4;
    localparam int OUT_W = 15;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in = '0;
    logic             in_mode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out;
    logic             out_err;
    logic             err_clr = 1'b0;
    logic [CNT_W-1:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [OUT_W:0] sb_q[$];

    enc_bin2onehot_stream #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in       (in),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .out_err  (out_err),
        .err_clr  (err_clr),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: {err, word}
    function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] idx,
                                             input logic mode);
        int ii;
        int v;
        logic [OUT_W-1:0] w;
        ii = int'(idx);
        if (ii >= OUT_W) begin
            w = mode ? {OUT_W{1'b1}} : '0;
            return {1'b1, w};
        end
        v = mode ? ((1 << (ii + 1)) - 1) : (1 << ii);
        w = v[OUT_W-1:0];
        return {1'b0, w};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_unexpected: got out=%h err=%b, queue empty",
                             out, out_err);
                end else begin
                    logic [OUT_W:0] e;
                    e = sb_q.pop_front();
                    if ({out_err, out} !== e) begin
                        n_bad++;
                        $display("FAIL sb_order: got err=%b out=%h, want err=%b out=%h",
                                 out_err, out, e[OUT_W], e[OUT_W-1:0]);
                    end
                end
            end
            if (in_valid && in_ready) sb_q.push_back(model(in, in_mode));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out !== '0 || out_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out: got v=%b out=%h err=%b, want 0/0/0",
                     out_valid, out, out_err);
        end
        n_cmp++;
        if (in_ready !== 1'b1 || err_cnt !== '0) begin
            n_bad++;
            $display("FAIL reset_ctl: got rdy=%b cnt=%0d, want 1/0",
                     in_ready, err_cnt);
        end
    endtask

    task automatic test_onehot_stream();
        logic [3:0]  idx[4];
        logic [14:0] exp[4];
        idx = '{4'd0, 4'd1, 4'd7, 4'd14};
        exp = '{15'h0001, 15'h0002, 15'h0080, 15'h4000};
        out_ready = 1'b1;
        in_mode   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in       = idx[k];
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out !== exp[k]) begin
                n_bad++;
                $display("FAIL onehot_%0d: got v=%b out=%h, want 1 %h",
                         k, out_valid, out, exp[k]);
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out !== '0) begin
            n_bad++;
            $display("FAIL onehot_drain: got v=%b out=%h, want 0 0",
                     out_valid, out);
        end
    endtask

    task automatic test_thermo();
        in_mode  = 1'b1;
        in_valid = 1'b1;
        in       = 4'd5;
        tick();
        n_cmp++;
        if (out !== 15'h003F || out_err !== 1'b0) begin
            n_bad++;
            $display("FAIL thermo_5: got out=%h err=%b, want 003f 0", out, out_err);
        end
        in = 4'd15;
        tick();
        n_cmp++;
        if (out !== 15'h7FFF || out_err !== 1'b1 || err_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL thermo_15: got out=%h err=%b cnt=%0d, want 7fff 1 1",
                     out, out_err, err_cnt);
        end
        in_valid = 1'b0;
        in_mode  = 1'b0;
        tick();
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in        = 4'd3;
        tick();
        in = 4'd9;
        tick();
        in = 4'd1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== 15'h0008) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: got rdy=%b v=%b out=%h, want 0 1 0008",
                         k, in_ready, out_valid, out);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out !== 15'h0200 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_second: got out=%h rdy=%b, want 0200 1", out, in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out !== 15'h0002) begin
            n_bad++;
            $display("FAIL bp_third: got out=%h, want 0002", out);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_drain: got v=%b, want 0", out_valid);
        end
    endtask

    task automatic test_errors();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++;
        if (err_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL err_clr: got cnt=%0d, want 0", err_cnt);
        end
        out_ready = 1'b1;
        in_mode   = 1'b0;
        in        = 4'd15;
        in_valid  = 1'b1;
        for (int k = 0; k < 17; k++) tick();
        in_valid = 1'b0;
        n_cmp++;
        if (err_cnt !== 4'd15) begin
            n_bad++;
            $display("FAIL err_sat: got cnt=%0d, want 15", err_cnt);
        end
        in_valid = 1'b1;
        err_clr  = 1'b1;
        tick();
        in_valid = 1'b0;
        err_clr  = 1'b0;
        n_cmp++;
        if (err_cnt !== 4'd1 || out !== '0 || out_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_clr_inc: got cnt=%0d out=%h err=%b, want 1 0 1",
                     err_cnt, out, out_err);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b1;
        in        = 4'd2;
        tick();
        in = 4'd4;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mr_full: got rdy=%b v=%b, want 0 1", in_ready, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out !== '0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mr_async: got v=%b out=%h rdy=%b, want 0 0 1",
                     out_valid, out, in_ready);
        end
        sb_q.delete();
        tick();
        tick();
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || out !== '0) begin
                n_bad++;
                $display("FAIL mr_stale_%0d: got v=%b out=%h, want 0 0",
                         k, out_valid, out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_onehot_stream();
        test_thermo();
        test_back_pressure();
        test_errors();
        test_mid_reset();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: got %0d beats pending, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
